// File: rtl/cci_mpf_shim_rob_mc.sv
// cci_mpf_shim_rob_mc -- multi-channel read-response reorder buffer.
//
// Each read is tagged {chan,slot} on the way to the FIU. Out-of-order FIU
// responses are parked in the owning slot and handed back to the AFU in
// request order, per channel. Channels are independent ordering domains.
// A stalled channel never blocks another. Ready channels share the single
// response port round-robin.
//
// Ports
//   clk, reset_n             clock, async active-low reset
//   afu_req_valid/chan/addr/mdata, afu_req_ready
//                            AFU read request; ready is combinational on chan
//   fiu_req_valid/addr/tag   registered request to the FIU
//   fiu_req_almfull          FIU backpressure
//   fiu_rsp_valid/tag/data   FIU read response (any order)
//   afu_rsp_valid/chan/mdata/data
//                            ordered response (no backpressure)
//   rob_err                  sticky tag error
//
// Build option
//   CCI_MPF_ROB_TAG_CHECK_EN  When defined, a response is dropped if it
//                             targets an unallocated slot or a slot that is
//                             already filled, and rob_err is set until
//                             reset. When undefined, tags are trusted and
//                             rob_err is tied to 0.

// Per-channel ring: pointers, occupancy, slot valid bits and slot storage.
module cci_mpf_shim_rob_mc_chan #(
  parameter int DEPTH       = 32,
  parameter int DATA_WIDTH  = 512,
  parameter int MDATA_WIDTH = 16,
  parameter int IW          = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   acc,
  input  logic [MDATA_WIDTH-1:0] acc_mdata,
  input  logic                   rsp_wr,
  input  logic [IW-1:0]          rsp_slot,
  input  logic [DATA_WIDTH-1:0]  rsp_data,
  input  logic                   deq,
`ifdef CCI_MPF_ROB_TAG_CHECK_EN
  output logic                   tag_err,
`endif
  output logic                   head_vld,
  output logic [MDATA_WIDTH-1:0] head_mdata,
  output logic [DATA_WIDTH-1:0]  head_data,
  output logic [IW-1:0]          wr_ptr,
  output logic                   full
);

  logic [IW-1:0]          rd_ptr;
  logic [IW:0]            count;
  logic [DEPTH-1:0]       vld;
  logic [MDATA_WIDTH-1:0] mdata_mem [DEPTH];
  logic [DATA_WIDTH-1:0]  data_mem  [DEPTH];
  logic [IW-1:0]          rsp_off;
  logic                   rsp_alloc;
  logic                   rsp_take;

  // A slot is live when its distance from the head is below the occupancy.
  assign rsp_off   = rsp_slot - rd_ptr;
  assign rsp_alloc = {1'b0, rsp_off} < count;

`ifdef CCI_MPF_ROB_TAG_CHECK_EN
  assign rsp_take = rsp_wr && rsp_alloc && !vld[rsp_slot];
  assign tag_err  = rsp_wr && !rsp_take;
`else
  assign rsp_take = rsp_wr && rsp_alloc;
`endif

  // DEPTH is a power of two and count never exceeds DEPTH.
  // So the MSB of count is set only when the channel is full.
  assign full       = count[IW];
  assign head_vld   = vld[rd_ptr];
  assign head_mdata = mdata_mem[rd_ptr];
  assign head_data  = data_mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else begin
      if (acc) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{IW{1'b0}}, acc} - {{IW{1'b0}}, deq};
      if (rsp_take) vld[rsp_slot] <= 1'b1;
      // The clear comes after the set. A stray duplicate aimed at the
      // departing head therefore cannot resurrect that slot.
      if (deq) vld[rd_ptr] <= 1'b0;
    end
  end

  // Payload storage needs no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (acc)      mdata_mem[wr_ptr]  <= acc_mdata;
    if (rsp_take) data_mem[rsp_slot] <= rsp_data;
  end

endmodule

module cci_mpf_shim_rob_mc #(
  parameter int N_CHANNELS  = 2,
  parameter int DEPTH       = 32,
  parameter int DATA_WIDTH  = 512,
  parameter int MDATA_WIDTH = 16,
  parameter int ADDR_WIDTH  = 42,
  localparam int CW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
  localparam int IW = $clog2(DEPTH),
  localparam int TW = CW + IW
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   afu_req_valid,
  input  logic [CW-1:0]          afu_req_chan,
  input  logic [ADDR_WIDTH-1:0]  afu_req_addr,
  input  logic [MDATA_WIDTH-1:0] afu_req_mdata,
  output logic                   afu_req_ready,
  output logic                   fiu_req_valid,
  output logic [ADDR_WIDTH-1:0]  fiu_req_addr,
  output logic [TW-1:0]          fiu_req_tag,
  input  logic                   fiu_req_almfull,
  input  logic                   fiu_rsp_valid,
  input  logic [TW-1:0]          fiu_rsp_tag,
  input  logic [DATA_WIDTH-1:0]  fiu_rsp_data,
  output logic                   afu_rsp_valid,
  output logic [CW-1:0]          afu_rsp_chan,
  output logic [MDATA_WIDTH-1:0] afu_rsp_mdata,
  output logic [DATA_WIDTH-1:0]  afu_rsp_data,
  output logic                   rob_err
);

  logic [N_CHANNELS-1:0]                  req_sel, rsp_sel, acc, rsp_wr, deq;
  logic [N_CHANNELS-1:0]                  head_vld, full;
  logic [N_CHANNELS-1:0][IW-1:0]          wr_ptr;
  logic [N_CHANNELS-1:0][MDATA_WIDTH-1:0] head_mdata;
  logic [N_CHANNELS-1:0][DATA_WIDTH-1:0]  head_data;
  logic [CW-1:0]                          rsp_chan;
  logic [IW-1:0]                          rsp_slot;
  logic                                   accept;
  logic [IW-1:0]                          acc_slot;
  logic [CW-1:0]                          rr_ptr, rr_next, win_idx;
  logic [CW:0]                            cand;
  logic                                   found;
  logic [MDATA_WIDTH-1:0]                 win_mdata;
  logic [DATA_WIDTH-1:0]                  win_data;

  assign rsp_chan = fiu_rsp_tag[TW-1:IW];
  assign rsp_slot = fiu_rsp_tag[IW-1:0];

  // Channel decode. An out-of-range channel code selects nothing.
  // Such a request is never ready, and such a response is never stored.
  always_comb begin
    req_sel = '0;
    rsp_sel = '0;
    for (int c = 0; c < N_CHANNELS; c++) begin
      req_sel[c] = (afu_req_chan == CW'(c));
      rsp_sel[c] = (rsp_chan == CW'(c));
    end
  end

  assign afu_req_ready = !fiu_req_almfull && |(req_sel & ~full);
  assign accept        = afu_req_valid && afu_req_ready;
  assign acc           = {N_CHANNELS{accept}} & req_sel;
  assign rsp_wr        = {N_CHANNELS{fiu_rsp_valid}} & rsp_sel;

  // Round-robin arbiter: scan from rr_ptr and take the first channel with a
  // filled head slot. cand has one extra bit so rr_ptr+i cannot overflow
  // before the wrap.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      cand = {1'b0, rr_ptr} + (CW+1)'(i);
      if (cand >= (CW+1)'(N_CHANNELS)) cand = cand - (CW+1)'(N_CHANNELS);
      if (!found && head_vld[cand[CW-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[CW-1:0];
      end
    end
  end

  assign rr_next = (win_idx == CW'(N_CHANNELS - 1)) ? '0 : win_idx + 1'b1;

  always_comb begin
    deq       = '0;
    win_mdata = '0;
    win_data  = '0;
    acc_slot  = '0;
    for (int c = 0; c < N_CHANNELS; c++) begin
      if (win_idx == CW'(c)) begin
        deq[c]    = found;
        win_mdata = head_mdata[c];
        win_data  = head_data[c];
      end
      if (req_sel[c]) acc_slot = wr_ptr[c];
    end
  end

`ifdef CCI_MPF_ROB_TAG_CHECK_EN
  logic [N_CHANNELS-1:0] tag_err;
`endif

  for (genvar c = 0; c < N_CHANNELS; c++) begin : g_chan
    cci_mpf_shim_rob_mc_chan #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .MDATA_WIDTH(MDATA_WIDTH),
      .IW         (IW)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .acc       (acc[c]),
      .acc_mdata (afu_req_mdata),
      .rsp_wr    (rsp_wr[c]),
      .rsp_slot  (rsp_slot),
      .rsp_data  (fiu_rsp_data),
      .deq       (deq[c]),
`ifdef CCI_MPF_ROB_TAG_CHECK_EN
      .tag_err   (tag_err[c]),
`endif
      .head_vld  (head_vld[c]),
      .head_mdata(head_mdata[c]),
      .head_data (head_data[c]),
      .wr_ptr    (wr_ptr[c]),
      .full      (full[c])
    );
  end

  // Registered FIU request and AFU response. The response payload holds its
  // last value while no channel is eligible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fiu_req_valid <= 1'b0;
      fiu_req_addr  <= '0;
      fiu_req_tag   <= '0;
      afu_rsp_valid <= 1'b0;
      afu_rsp_chan  <= '0;
      afu_rsp_mdata <= '0;
      afu_rsp_data  <= '0;
      rr_ptr        <= '0;
    end else begin
      fiu_req_valid <= accept;
      if (accept) begin
        fiu_req_addr <= afu_req_addr;
        fiu_req_tag  <= {afu_req_chan, acc_slot};
      end
      afu_rsp_valid <= found;
      if (found) begin
        afu_rsp_chan  <= win_idx;
        afu_rsp_mdata <= win_mdata;
        afu_rsp_data  <= win_data;
        rr_ptr        <= rr_next;
      end
    end
  end

`ifdef CCI_MPF_ROB_TAG_CHECK_EN
  // A response whose channel code is out of range is also an error.
  logic rsp_chan_bad;
  assign rsp_chan_bad = fiu_rsp_valid && !(|rsp_sel);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        rob_err <= 1'b0;
    else if (|tag_err || rsp_chan_bad)  rob_err <= 1'b1;
  end
`else
  assign rob_err = 1'b0;
`endif

endmodule
